// File: rtl/clock_edge_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : clock_edge_tracker
// Brief    : Resynchronises a slow divided clock into clkin-domain rise/fall
//            enables, measures its period and high time, and tracks lock.
// Revision : 1.0
// =============================================================================

module clock_edge_tracker #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             divclk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             glitch
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   C_TOL     = (CNT_W+1)'(TOL);
  localparam logic [3:0]       C_LOCK    = 4'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   r_p;
  logic                   r_rise_det;
  logic                   r_fall_det;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_prev_p;
  logic [3:0]             r_match_cnt;
  state_t                 r_state;

  state_t                 w_state_next;
  logic [CNT_W-1:0]       w_prev_p_next;
  logic [CNT_W-1:0]       w_period_next;
  logic [3:0]             w_match_next;
  logic                   w_glitch_next;
  logic [CNT_W:0]         w_diff;
  logic                   w_match;
  logic                   w_timeout;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Edge detection is registered once more so that strobes and measurement
  // updates land together, SYNC_STAGES+1 edges after the first sample.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_sync     <= '0;
      r_p        <= 1'b0;
      r_rise_det <= 1'b0;
      r_fall_det <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], divclk_in};
      r_p        <= w_s;
      r_rise_det <= w_s & ~r_p;
      r_fall_det <= ~w_s & r_p;
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      high_time  <= '0;
    end else begin
      rise_pulse <= r_rise_det;
      fall_pulse <= r_fall_det;
      if (r_rise_det) begin
        r_cnt <= C_CNT_ONE;
      end else if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_fall_det) begin
        high_time <= r_cnt;
      end
    end
  end

  // Widened by one bit so the absolute difference never wraps.
  assign w_diff    = (r_cnt >= r_prev_p) ? ({1'b0, r_cnt} - {1'b0, r_prev_p})
                                         : ({1'b0, r_prev_p} - {1'b0, r_cnt});
  assign w_match   = (w_diff <= C_TOL);
  assign w_timeout = (r_cnt == C_CNT_MAX) && !r_rise_det && (r_state != ST_IDLE);

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_match_cnt <= '0;
      r_prev_p    <= '0;
      period      <= '0;
      glitch      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_match_cnt <= w_match_next;
      r_prev_p    <= w_prev_p_next;
      period      <= w_period_next;
      glitch      <= w_glitch_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_match_next  = r_match_cnt;
    w_prev_p_next = r_prev_p;
    w_period_next = period;
    w_glitch_next = 1'b0;
    if (r_rise_det) begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_MEASURE;
        end
        ST_MEASURE: begin
          w_period_next = r_cnt;
          w_prev_p_next = r_cnt;
          w_match_next  = '0;
          w_state_next  = ST_TRACK;
        end
        ST_TRACK: begin
          w_period_next = r_cnt;
          w_prev_p_next = r_cnt;
          if (w_match) begin
            w_match_next = r_match_cnt + 4'd1;
            if ((r_match_cnt + 4'd1) == C_LOCK) begin
              w_state_next = ST_LOCKED;
            end
          end else begin
            w_match_next = '0;
          end
        end
        ST_LOCKED: begin
          w_period_next = r_cnt;
          w_prev_p_next = r_cnt;
          if (!w_match) begin
            w_match_next  = '0;
            w_state_next  = ST_TRACK;
            w_glitch_next = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end else if (w_timeout) begin
      w_state_next  = ST_IDLE;
      w_period_next = C_CNT_MAX;
      w_glitch_next = 1'b1;
    end
  end

  assign locked = (r_state == ST_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_clock_edge_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_clock_edge_tracker
// Brief    : Directed, table-driven self-checking bench for clock_edge_tracker.
// Revision : 1.0
// =============================================================================

module tb_clock_edge_tracker;

  localparam int CNT_W = 8;

  logic             clkin     = 1'b0;
  logic             rstn      = 1'b0;
  logic             divclk_in = 1'b0;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             locked;
  logic             glitch;

  int n_checks = 0;
  int n_errors = 0;

  // One divided-clock period: hi cycles high then lo cycles low. Expected
  // values are those seen 3 cycles after the input rise (the rise strobe).
  typedef struct {
    int hi;
    int lo;
    int exp_period;
    int exp_high;
    int exp_locked;
    int exp_glitch;
  } seg_t;

  seg_t vec [27];

  clock_edge_tracker #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .LOCK_COUNT (4),
    .TOL        (1)
  ) dut (
    .clkin     (clkin),
    .rstn      (rstn),
    .divclk_in (divclk_in),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .period    (period),
    .high_time (high_time),
    .locked    (locked),
    .glitch    (glitch)
  );

  always #5 clkin = ~clkin;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic run_seg(input int idx);
    int hi, lo, n_rise, n_fall, n_gl, fall_at;
    logic rise3, gl3, lk3;
    logic [CNT_W-1:0] per3, ht3;
    hi = vec[idx].hi;
    lo = vec[idx].lo;
    n_rise = 0; n_fall = 0; n_gl = 0; fall_at = -1;
    rise3 = 1'b0; gl3 = 1'b0; lk3 = 1'b0; per3 = '0; ht3 = '0;
    for (int c = 0; c < hi + lo; c++) begin
      @(negedge clkin);
      divclk_in = (c < hi);
      @(posedge clkin);
      #1;
      if (rise_pulse) n_rise++;
      if (fall_pulse) begin
        n_fall++;
        if (fall_at < 0) fall_at = c;
      end
      if (glitch) n_gl++;
      if (c == 3) begin
        rise3 = rise_pulse; gl3 = glitch; lk3 = locked; per3 = period; ht3 = high_time;
      end
    end
    check($sformatf("seg%0d rise_latency", idx), rise3, 1);
    check($sformatf("seg%0d rise_count", idx), n_rise, 1);
    check($sformatf("seg%0d fall_latency", idx), fall_at, hi + 3);
    check($sformatf("seg%0d fall_count", idx), n_fall, 1);
    check($sformatf("seg%0d period", idx), per3, vec[idx].exp_period);
    check($sformatf("seg%0d high_time", idx), ht3, vec[idx].exp_high);
    check($sformatf("seg%0d locked", idx), lk3, vec[idx].exp_locked);
    check($sformatf("seg%0d glitch_at_rise", idx), gl3, vec[idx].exp_glitch);
    check($sformatf("seg%0d glitch_count", idx), n_gl, vec[idx].exp_glitch);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " rise_pulse"}, rise_pulse, 0);
    check({tag, " fall_pulse"}, fall_pulse, 0);
    check({tag, " period"}, period, 0);
    check({tag, " high_time"}, high_time, 0);
    check({tag, " locked"}, locked, 0);
    check({tag, " glitch"}, glitch, 0);
  endtask

  initial begin
    int got;
    logic prev_lk;

    // Steady 8 (4/4), lock on 6th rise, stretch to 9, jump to 12, relock.
    vec[0]  = '{4, 4,   0, 0, 0, 0};
    vec[1]  = '{4, 4,   8, 4, 0, 0};
    vec[2]  = '{4, 4,   8, 4, 0, 0};
    vec[3]  = '{4, 4,   8, 4, 0, 0};
    vec[4]  = '{4, 4,   8, 4, 0, 0};
    vec[5]  = '{4, 4,   8, 4, 1, 0};
    vec[6]  = '{4, 4,   8, 4, 1, 0};
    vec[7]  = '{5, 4,   8, 4, 1, 0};
    vec[8]  = '{4, 8,   9, 5, 1, 0};
    vec[9]  = '{6, 6,  12, 4, 0, 1};
    vec[10] = '{6, 6,  12, 6, 0, 0};
    vec[11] = '{6, 6,  12, 6, 0, 0};
    vec[12] = '{6, 6,  12, 6, 0, 0};
    vec[13] = '{6, 6,  12, 6, 1, 0};
    // Restart after timeout: period holds 255 until the second rise.
    vec[14] = '{4, 4, 255, 6, 0, 0};
    vec[15] = '{4, 4,   8, 4, 0, 0};
    vec[16] = '{4, 4,   8, 4, 0, 0};
    vec[17] = '{4, 4,   8, 4, 0, 0};
    vec[18] = '{4, 4,   8, 4, 0, 0};
    vec[19] = '{4, 4,   8, 4, 1, 0};
    // Jitter alternating 8 and 10: never locks, never glitches.
    vec[20] = '{4, 4,   0, 0, 0, 0};
    vec[21] = '{5, 5,   8, 4, 0, 0};
    vec[22] = '{4, 4,  10, 5, 0, 0};
    vec[23] = '{5, 5,   8, 4, 0, 0};
    vec[24] = '{4, 4,  10, 5, 0, 0};
    vec[25] = '{5, 5,   8, 4, 0, 0};
    vec[26] = '{4, 4,  10, 5, 0, 0};

    // Reset held with the input high; first synchronised level gives a rise.
    divclk_in = 1'b1;
    repeat (3) @(posedge clkin);
    #1;
    check_outputs_zero("reset_high");
    @(posedge clkin);
    #2 rstn = 1'b1;
    for (int i = 0; i <= 13; i++) run_seg(i);

    // Input stops low while locked; last rise was 8 edges ago.
    got = 0;
    prev_lk = 1'b0;
    for (int n = 9; n <= 300; n++) begin
      @(posedge clkin);
      #1;
      if (glitch) begin
        got = n;
        break;
      end
      prev_lk = locked;
    end
    check("timeout_edge", got, 255);
    check("timeout_locked_before", prev_lk, 1);
    check("timeout_period", period, 255);
    check("timeout_locked", locked, 0);
    check("timeout_high_kept", high_time, 6);
    @(posedge clkin);
    #1;
    check("timeout_glitch_once", glitch, 0);
    for (int i = 14; i <= 19; i++) run_seg(i);

    // Asynchronous reset in the middle of a locked period.
    @(negedge clkin);
    divclk_in = 1'b1;
    @(posedge clkin);
    #3;
    check("pre_reset_locked", locked, 1);
    rstn = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    divclk_in = 1'b0;
    repeat (3) @(posedge clkin);
    @(posedge clkin);
    #2 rstn = 1'b1;
    for (int i = 0; i <= 5; i++) run_seg(i);

    // Fresh start with a jittered input.
    rstn = 1'b0;
    divclk_in = 1'b0;
    repeat (3) @(posedge clkin);
    @(posedge clkin);
    #2 rstn = 1'b1;
    for (int i = 20; i <= 26; i++) run_seg(i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
